ram_port_arbiter: RTL and testbench

Shares one single-port synchronous block RAM between the core's instruction-fetch and data ports. It presents the core the same req/gnt/rvalid protocol the dual-port RAM wrapper provides. It arbitrates per cycle, drives the shared memory port, and uses a tag pipeline to route each response back to the requester that issued it. It sits between the RI5CY core and the memory macro in FPGA builds that have only one BRAM port available.

---
 rtl/ram_port_arbiter.sv | 129 ++++++++++++
 tb/tb_ram_port_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Shares one single-port synchronous BRAM between the fetch and data ports of the core.
// Optional RAM_ARB_RR_EN: round-robin arbitration replaces data priority plus starvation limit.
module ram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned MEM_AW       = 16,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  mem_en_o,
  output logic [3:0]            mem_we_o,
  output logic [MEM_AW-1:0]     mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i,
  output logic [15:0]           conflict_cnt_o
);

  localparam logic OwnInstr = 1'b0;
  localparam logic OwnData  = 1'b1;

  logic                   conflict;
  logic                   pick_instr;
  logic                   pick_data;
  logic                   grant_instr;
  logic                   grant_data;
  logic                   grant_any;
  logic [7:0]             starve_q;
  logic [7:0]             starve_d;
  logic [15:0]            conflict_q;
  logic [MEM_LATENCY-1:0] tag_valid_q;
  logic [MEM_LATENCY-1:0] tag_owner_q;
  logic                   unused_addr_bits;

  assign conflict = instr_req_i & data_req_i;

`ifdef RAM_ARB_RR_EN
  logic last_owner_q;
  logic last_owner_d;

  // On a conflict the requester that was not granted most recently wins.
  always_comb begin
    pick_instr   = instr_req_i;
    pick_data    = data_req_i;
    last_owner_d = last_owner_q;
    if (conflict) begin
      pick_instr = (last_owner_q == OwnData);
      pick_data  = ~pick_instr;
    end
    if (pick_instr) begin
      last_owner_d = OwnInstr;
    end else if (pick_data) begin
      last_owner_d = OwnData;
    end
    starve_d = 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= OwnInstr;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  // Data wins conflicts unless fetch has been denied STARVE_LIMIT cycles in a row.
  always_comb begin
    pick_instr = instr_req_i;
    pick_data  = data_req_i;
    if (conflict) begin
      pick_instr = (starve_q == 8'(STARVE_LIMIT));
      pick_data  = ~pick_instr;
    end
    starve_d = (instr_req_i && !pick_instr) ? starve_q + 8'd1 : 8'd0;
  end
`endif

  // Reset also gates the combinational grants so nothing reaches memory while in reset.
  assign grant_instr = pick_instr & rst_n;
  assign grant_data  = pick_data & rst_n;
  assign grant_any   = grant_instr | grant_data;

  assign instr_gnt_o = grant_instr;
  assign data_gnt_o  = grant_data;

  assign mem_en_o    = grant_any;
  assign mem_we_o    = (grant_data && data_we_i) ? data_be_i : 4'b0000;
  assign mem_addr_o  = grant_data ? data_addr_i[MEM_AW+1:2] : instr_addr_i[MEM_AW+1:2];
  assign mem_wdata_o = data_wdata_i;

  assign unused_addr_bits = ^{instr_addr_i, data_addr_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q    <= 8'd0;
      conflict_q  <= 16'd0;
      tag_valid_q <= '0;
      tag_owner_q <= '0;
    end else begin
      starve_q <= starve_d;
      if (conflict && (conflict_q != 16'hFFFF)) begin
        conflict_q <= conflict_q + 16'd1;
      end
      // Stage 0 takes this cycle's grant; the last stage lines up with mem_rdata_i.
      tag_valid_q <= MEM_LATENCY'({tag_valid_q, grant_any});
      tag_owner_q <= MEM_LATENCY'({tag_owner_q, grant_data});
    end
  end

  assign instr_rvalid_o = tag_valid_q[MEM_LATENCY-1] & (tag_owner_q[MEM_LATENCY-1] == OwnInstr);
  assign data_rvalid_o  = tag_valid_q[MEM_LATENCY-1] & (tag_owner_q[MEM_LATENCY-1] == OwnData);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign conflict_cnt_o = conflict_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: vector table, corner sequences, random vs model.
module tb_ram_port_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned MAW   = 16;
  localparam int unsigned LAT   = 2;
  localparam int unsigned LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ireq;
  logic [AW-1:0] iaddr;
  logic          ignt;
  logic          irvalid;
  logic [31:0]   irdata;
  logic          dreq;
  logic [AW-1:0] daddr;
  logic          dwe;
  logic [3:0]    dbe;
  logic [31:0]   dwdata;
  logic          dgnt;
  logic          drvalid;
  logic [31:0]   drdata;
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [MAW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic [15:0]   ccnt;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .ADDR_WIDTH  (AW),
    .MEM_AW      (MAW),
    .MEM_LATENCY (LAT),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_req_i   (ireq),
    .instr_addr_i  (iaddr),
    .instr_gnt_o   (ignt),
    .instr_rvalid_o(irvalid),
    .instr_rdata_o (irdata),
    .data_req_i    (dreq),
    .data_addr_i   (daddr),
    .data_we_i     (dwe),
    .data_be_i     (dbe),
    .data_wdata_i  (dwdata),
    .data_gnt_o    (dgnt),
    .data_rvalid_o (drvalid),
    .data_rdata_o  (drdata),
    .mem_en_o      (mem_en),
    .mem_we_o      (mem_we),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .mem_rdata_i   (mem_rdata),
    .conflict_cnt_o(ccnt)
  );

  // Read-first BRAM with LAT-cycle read latency, driven by the DUT memory port.
  logic [31:0] ram     [256];
  logic [31:0] rd_pipe [LAT];

  always @(posedge clk) begin
    rd_pipe[0] <= mem_en ? ram[mem_addr[7:0]] : $urandom;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // Reference model state.
  typedef struct {
    int          due;
    bit          owner;
    bit          rd;
    logic [31:0] data;
  } resp_t;

  resp_t       sb[$];
  logic [31:0] ref_ram [256];
  int          starve;
  int          conflicts;
  int          cyc;
  int          total;
  int          bad;
  bit          last_data;
  bit          eg_i;
  bit          eg_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at the negedge: checks this cycle's outputs, then advances the model.
  task automatic model_cycle();
    bit          er_i;
    bit          er_d;
    logic [7:0]  idx;
    logic [31:0] word;
    eg_i = 1'b0;
    eg_d = 1'b0;
    if (rst_n) begin
      if (ireq && dreq) begin
`ifdef RAM_ARB_RR_EN
        if (last_data) eg_i = 1'b1;
        else eg_d = 1'b1;
`else
        if (starve == int'(LIMIT)) eg_i = 1'b1;
        else eg_d = 1'b1;
`endif
      end else begin
        eg_i = ireq;
        eg_d = dreq;
      end
    end
    check("instr_gnt", ignt, eg_i);
    check("data_gnt", dgnt, eg_d);
    check("mem_en", mem_en, eg_i | eg_d);
    if (eg_i || eg_d) check("mem_addr", mem_addr, eg_d ? daddr[MAW+1:2] : iaddr[MAW+1:2]);
    check("mem_we", mem_we, (eg_d && dwe) ? dbe : 4'h0);
    if (eg_d && dwe) check("mem_wdata", mem_wdata, dwdata);
    er_i = (sb.size() > 0) && (sb[0].due == cyc) && !sb[0].owner;
    er_d = (sb.size() > 0) && (sb[0].due == cyc) && sb[0].owner;
    check("instr_rvalid", irvalid, er_i);
    check("data_rvalid", drvalid, er_d);
    if (er_i && sb[0].rd) check("instr_rdata", irdata, sb[0].data);
    if (er_d && sb[0].rd) check("data_rdata", drdata, sb[0].data);
    if (er_i || er_d) void'(sb.pop_front());
    check("conflict_cnt", ccnt, conflicts);
    if (rst_n) begin
      if (ireq && dreq && conflicts < 65535) conflicts++;
`ifdef RAM_ARB_RR_EN
      starve = 0;
`else
      starve = (ireq && !eg_i) ? starve + 1 : 0;
`endif
      if (eg_i) last_data = 1'b0;
      else if (eg_d) last_data = 1'b1;
      if (eg_i || eg_d) begin
        idx  = eg_d ? daddr[9:2] : iaddr[9:2];
        word = ref_ram[idx];
        if (eg_d && dwe) begin
          for (int b = 0; b < 4; b++) if (dbe[b]) ref_ram[idx][8*b +: 8] = dwdata[8*b +: 8];
        end
        sb.push_back('{cyc + int'(LAT), eg_d, !(eg_d && dwe), word});
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic assert_reset();
    rst_n     = 1'b0;
    sb.delete();
    starve    = 0;
    conflicts = 0;
    last_data = 1'b0;
  endtask

  task automatic go_idle();
    ireq = 1'b0;
    dreq = 1'b0;
    dwe  = 1'b0;
  endtask

  typedef struct {
    bit          ireq;
    logic [31:0] iaddr;
    bit          dreq;
    logic [31:0] daddr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          e_ig;
    bit          e_dg;
    logic [15:0] e_addr;
    logic [3:0]  e_we;
  } vec_t;

  vec_t tbl [8];
  bit   exp_ig;

  initial begin
    tbl[0] = '{1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 16'h0004, 4'h0};
    tbl[1] = '{1'b1, 32'h0000_0010, 1'b1, 32'h0000_0020, 1'b1, 4'b0011, 32'h1234_5678,
               1'b0, 1'b1, 16'h0008, 4'b0011};
    tbl[2] = '{1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 16'h0004, 4'h0};
    tbl[3] = '{1'b0, 32'h0, 1'b1, 32'h0000_0040, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 16'h0010, 4'h0};
    tbl[4] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 16'h0000, 4'h0};
    tbl[5] = '{1'b0, 32'h0, 1'b1, 32'h0003_FFFC, 1'b1, 4'hF, 32'hCAFE_F00D,
               1'b0, 1'b1, 16'hFFFF, 4'hF};
    tbl[6] = '{1'b1, 32'hFFFF_FFF0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 16'hFFFC, 4'h0};
    tbl[7] = '{1'b0, 32'h0, 1'b1, 32'h0000_0020, 1'b0, 4'hF, 32'h0, 1'b0, 1'b1, 16'h0008, 4'h0};

    for (int i = 0; i < 256; i++) begin
      ram[i]     = (i * 32'h0101_0101) ^ 32'hA500_0000;
      ref_ram[i] = (i * 32'h0101_0101) ^ 32'hA500_0000;
    end
    total = 0;
    bad   = 0;
    cyc   = 0;
    iaddr = '0;
    daddr = '0;
    dbe   = '0;
    dwdata = '0;
    dwe   = 1'b0;
    ireq  = 1'b1;
    dreq  = 1'b1;
    rst_n = 1'b1;
    #1;
    assert_reset();

    // Reset state with both requests raised.
    @(negedge clk);
    check("rst_igt", ignt, 1'b0);
    check("rst_dgt", dgnt, 1'b0);
    check("rst_en", mem_en, 1'b0);
    check("rst_we", mem_we, 4'h0);
    check("rst_cnt", ccnt, 16'h0);
    model_cycle();
    @(posedge clk);
    #1;
    go_idle();
    tick();
    rst_n = 1'b1;
    tick();

    // Vector table.
    for (int k = 0; k < 8; k++) begin
      ireq   = tbl[k].ireq;
      iaddr  = tbl[k].iaddr;
      dreq   = tbl[k].dreq;
      daddr  = tbl[k].daddr;
      dwe    = tbl[k].we;
      dbe    = tbl[k].be;
      dwdata = tbl[k].wd;
      @(negedge clk);
      check("tbl_igt", ignt, tbl[k].e_ig);
      check("tbl_dgt", dgnt, tbl[k].e_dg);
      if (tbl[k].e_ig || tbl[k].e_dg) check("tbl_addr", mem_addr, tbl[k].e_addr);
      check("tbl_we", mem_we, tbl[k].e_we);
      model_cycle();
      @(posedge clk);
      #1;
    end
    go_idle();
    for (int k = 0; k < 3; k++) tick();
    check("tbl_conflicts", ccnt, 16'd1);

    // Pipelining: d, i, d, i then idle; responses two cycles later in issue order.
    for (int k = 0; k < 6; k++) begin
      go_idle();
      if (k < 4) begin
        if (k % 2 == 0) begin
          dreq  = 1'b1;
          daddr = 32'h100 + 32'(k * 4);
        end else begin
          ireq  = 1'b1;
          iaddr = 32'h200 + 32'(k * 4);
        end
      end
      @(negedge clk);
      check("pipe_drv", drvalid, (k == 2) || (k == 4));
      check("pipe_irv", irvalid, (k == 3) || (k == 5));
      model_cycle();
      @(posedge clk);
      #1;
    end

    // Both requesters held high from a clean reset.
    assert_reset();
    tick();
    rst_n = 1'b1;
    ireq  = 1'b1;
    dreq  = 1'b1;
    iaddr = 32'h40;
    daddr = 32'h80;
    for (int k = 0; k < 15; k++) begin
`ifdef RAM_ARB_RR_EN
      exp_ig = (k % 2 == 1);
`else
      exp_ig = (k % 5 == int'(LIMIT));
`endif
      @(negedge clk);
      check("hold_igt", ignt, exp_ig);
      check("hold_dgt", dgnt, !exp_ig);
      model_cycle();
      @(posedge clk);
      #1;
    end
    go_idle();
    for (int k = 0; k < 3; k++) tick();

    // Reset while a response is in flight.
    ireq = 1'b1;
    dreq = 1'b1;
    tick();
    assert_reset();
    tick();
    tick();
    go_idle();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("flight_irv", irvalid, 1'b0);
      check("flight_drv", drvalid, 1'b0);
      model_cycle();
      @(posedge clk);
      #1;
    end
    check("flight_cnt", ccnt, 16'd0);

    // Random traffic obeying the hold-until-granted protocol.
    for (int n = 0; n < 3000; n++) begin
      if (!(ireq && !eg_i)) begin
        ireq  = ($urandom_range(0, 3) != 0);
        iaddr = $urandom;
      end
      if (!(dreq && !eg_d)) begin
        dreq   = ($urandom_range(0, 3) != 0);
        daddr  = $urandom;
        dwe    = 1'($urandom_range(0, 1));
        dbe    = 4'($urandom);
        dwdata = $urandom;
      end
      if (n % 700 == 699) begin
        assert_reset();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    go_idle();
    for (int k = 0; k < 4; k++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
